// File: rtl/cpu_instrmem_pq_if.sv
// Loader / fetch bus of the instruction memory.
// The master side drives the load and fetch requests, and the slave side is the memory.
interface cpu_instrmem_pq_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic                  ld_valid;
  logic                  ld_ready;
  logic [ADDR_W-1:0]     ld_addr;
  logic [DATA_W-1:0]     ld_data;
  logic [DATA_W/8-1:0]   ld_be;
  logic                  ld_done;
  logic                  fetch_req;
  logic                  fetch_gnt;
  logic [ADDR_W-1:0]     fetch_addr;
  logic                  instr_valid;
  logic [DATA_W-1:0]     instr_out;
  logic                  err_align;
  logic                  err_range;
  logic [7:0]            err_cnt;
  logic [1:0]            state;

  modport master (
    output ld_valid, ld_addr, ld_data, ld_be, ld_done, fetch_req, fetch_addr,
    input  ld_ready, fetch_gnt, instr_valid, instr_out, err_align, err_range,
           err_cnt, state
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data, ld_be, ld_done, fetch_req, fetch_addr,
    output ld_ready, fetch_gnt, instr_valid, instr_out, err_align, err_range,
           err_cnt, state
  );
endinterface

// File: rtl/cpu_instrmem_pq.sv
// Instruction memory with a byte-enabled loader port and a single-cycle fetch port.
// A small FSM (IDLE/LOAD/RUN) gates fetching until the loader reports done.
// In RUN, a fetch takes priority over a concurrent load.
module cpu_instrmem_pq #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16384
) (
  input  logic               clk,
  input  logic               rst_n,
  cpu_instrmem_pq_if.slave   bus
);

  localparam int BPW   = DATA_W / 8;
  localparam int OFF_W = $clog2(BPW);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BPW - 1);
  localparam logic [ADDR_W:0]   DEPTH_L    = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10
  } state_t;

  // Address classification helpers shared by the load and fetch paths.
  function automatic logic is_aligned(input logic [ADDR_W-1:0] a);
    return (a & ALIGN_MASK) == {ADDR_W{1'b0}};
  endfunction

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, (a >> OFF_W)} < DEPTH_L;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a >> OFF_W);
  endfunction

  state_t             state_r;
  logic               instr_valid_r;
  logic [DATA_W-1:0]  instr_out_r;
  logic               err_align_r;
  logic               err_range_r;
  logic [7:0]         err_cnt_r;

  logic [DATA_W-1:0]  mem_r [DEPTH];

  logic               ld_ready_s;
  logic               fetch_gnt_s;
  logic               ld_acc_s;
  logic               ld_ok_s;
  logic               ld_ea_s;
  logic               ld_er_s;
  logic               f_acc_s;
  logic               f_ok_s;
  logic               f_ea_s;
  logic               f_er_s;
  logic               ea_nxt_s;
  logic               er_nxt_s;
  logic [IDX_W-1:0]   ld_idx_s;
  logic [IDX_W-1:0]   f_idx_s;

  // Handshake decode and error classification for both ports.
  always_comb begin
    ld_ready_s  = 1'b1;
    fetch_gnt_s = 1'b0;
    if (state_r == ST_RUN) begin
      ld_ready_s  = !bus.fetch_req;
      fetch_gnt_s = bus.fetch_req;
    end else begin
      ld_ready_s  = 1'b1;
      fetch_gnt_s = 1'b0;
    end

    ld_acc_s = bus.ld_valid && ld_ready_s;
    f_acc_s  = fetch_gnt_s;

    // Misalignment masks a range error so only one flag fires per source.
    ld_ea_s = ld_acc_s && !is_aligned(bus.ld_addr);
    ld_er_s = ld_acc_s && is_aligned(bus.ld_addr) && !in_range(bus.ld_addr);
    ld_ok_s = ld_acc_s && is_aligned(bus.ld_addr) && in_range(bus.ld_addr);

    f_ea_s  = f_acc_s && !is_aligned(bus.fetch_addr);
    f_er_s  = f_acc_s && is_aligned(bus.fetch_addr) && !in_range(bus.fetch_addr);
    f_ok_s  = f_acc_s && is_aligned(bus.fetch_addr) && in_range(bus.fetch_addr);

    ea_nxt_s = ld_ea_s || f_ea_s;
    er_nxt_s = ld_er_s || f_er_s;

    ld_idx_s = word_idx(bus.ld_addr);
    f_idx_s  = word_idx(bus.fetch_addr);
  end

  // Byte-lane storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (ld_ok_s) begin
      for (int k = 0; k < BPW; k++) begin
        if (bus.ld_be[k]) begin
          mem_r[ld_idx_s][8*k +: 8] <= bus.ld_data[8*k +: 8];
        end
      end
    end
  end

  // Control FSM together with the registered fetch result and error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      instr_valid_r <= 1'b0;
      instr_out_r   <= {DATA_W{1'b0}};
      err_align_r   <= 1'b0;
      err_range_r   <= 1'b0;
      err_cnt_r     <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.ld_done) begin
            state_r <= ST_RUN;
          end else if (bus.ld_valid) begin
            state_r <= ST_LOAD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (bus.ld_done) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_LOAD;
          end
        end
        ST_RUN: begin
          state_r <= ST_RUN;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase

      instr_valid_r <= f_acc_s;
      if (f_ok_s) begin
        instr_out_r <= mem_r[f_idx_s];
      end else if (f_acc_s) begin
        instr_out_r <= {DATA_W{1'b0}};
      end else begin
        instr_out_r <= instr_out_r;
      end

      err_align_r <= ea_nxt_s;
      err_range_r <= er_nxt_s;

      // Counted on the same edge that raises the flag, so the count matches the visible pulse.
      if ((ea_nxt_s || er_nxt_s) && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end else begin
        err_cnt_r <= err_cnt_r;
      end
    end
  end

  assign bus.ld_ready    = ld_ready_s;
  assign bus.fetch_gnt   = fetch_gnt_s;
  assign bus.instr_valid = instr_valid_r;
  assign bus.instr_out   = instr_out_r;
  assign bus.err_align   = err_align_r;
  assign bus.err_range   = err_range_r;
  assign bus.err_cnt     = err_cnt_r;
  assign bus.state       = state_r;

endmodule

// File: tb/tb_cpu_instrmem_pq.sv
// Scoreboard bench for cpu_instrmem_pq (DEPTH = 1024 words, 32-bit data).
// Each fetch grant pushes its expected word, and each instr_valid pops and compares it.
module tb_cpu_instrmem_pq;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_LOAD = 2'b01;
  localparam logic [1:0] S_RUN  = 2'b10;

  logic clk;
  logic rst_n;

  cpu_instrmem_pq_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  cpu_instrmem_pq #(.ADDR_W(16), .DATA_W(32), .DEPTH(1024)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_chk;
  int          n_err;
  logic [31:0] sb_q [$];
  logic [7:0]  mdl [4096];
  logic [1:0]  exp_state;
  logic [7:0]  exp_cnt;
  logic [31:0] exp_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive the inputs, check the handshake, predict, clock, then check the registered outputs.
  task automatic tick(input logic ldv, input logic [15:0] la, input logic [31:0] ld,
                      input logic [3:0] lbe, input logic ldn,
                      input logic fr, input logic [15:0] fa);
    logic acc_l, acc_f, ea, er;
    logic [31:0] got_q;
    bus.ld_valid   = ldv;
    bus.ld_addr    = la;
    bus.ld_data    = ld;
    bus.ld_be      = lbe;
    bus.ld_done    = ldn;
    bus.fetch_req  = fr;
    bus.fetch_addr = fa;
    #1;
    check_val("state", {30'd0, bus.state}, {30'd0, exp_state});
    check_val("ld_ready", {31'd0, bus.ld_ready}, {31'd0, !(exp_state == S_RUN && fr)});
    check_val("fetch_gnt", {31'd0, bus.fetch_gnt}, {31'd0, (exp_state == S_RUN && fr)});
    acc_f = fr && (exp_state == S_RUN);
    acc_l = ldv && !acc_f;
    ea = 1'b0;
    er = 1'b0;
    if (acc_f) begin
      if (fa[1:0] != 2'b00) begin
        ea = 1'b1;
        sb_q.push_back(32'h0);
      end else if (fa >= 16'h1000) begin
        er = 1'b1;
        sb_q.push_back(32'h0);
      end else begin
        sb_q.push_back({mdl[int'(fa)+3], mdl[int'(fa)+2], mdl[int'(fa)+1], mdl[int'(fa)]});
      end
    end
    if (acc_l) begin
      if (la[1:0] != 2'b00) ea = 1'b1;
      else if (la >= 16'h1000) er = 1'b1;
      else begin
        for (int k = 0; k < 4; k++) begin
          if (lbe[k]) mdl[int'(la)+k] = ld[8*k +: 8];
        end
      end
    end
    if ((ea || er) && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
    case (exp_state)
      S_IDLE:  exp_state = ldn ? S_RUN : (ldv ? S_LOAD : S_IDLE);
      S_LOAD:  exp_state = ldn ? S_RUN : S_LOAD;
      default: exp_state = S_RUN;
    endcase
    @(posedge clk);
    #1;
    check_val("instr_valid", {31'd0, bus.instr_valid}, {31'd0, acc_f});
    if (bus.instr_valid) begin
      check_val("sb_nonempty", {31'd0, (sb_q.size() != 0)}, 32'd1);
      if (sb_q.size() != 0) begin
        got_q = sb_q.pop_front();
        exp_out = got_q;
      end
    end
    check_val("instr_out", bus.instr_out, exp_out);
    check_val("err_align", {31'd0, bus.err_align}, {31'd0, ea});
    check_val("err_range", {31'd0, bus.err_range}, {31'd0, er});
    check_val("err_cnt", {24'd0, bus.err_cnt}, {24'd0, exp_cnt});
  endtask

  task automatic idle();
    tick(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_state"}, {30'd0, bus.state}, 32'd0);
    check_val({tag, "_valid"}, {31'd0, bus.instr_valid}, 32'd0);
    check_val({tag, "_out"}, bus.instr_out, 32'd0);
    check_val({tag, "_ea"}, {31'd0, bus.err_align}, 32'd0);
    check_val({tag, "_er"}, {31'd0, bus.err_range}, 32'd0);
    check_val({tag, "_cnt"}, {24'd0, bus.err_cnt}, 32'd0);
    check_val({tag, "_gnt"}, {31'd0, bus.fetch_gnt}, 32'd0);
    check_val({tag, "_rdy"}, {31'd0, bus.ld_ready}, 32'd1);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    exp_state = S_IDLE;
    exp_cnt = 8'd0;
    exp_out = 32'd0;
    for (int i = 0; i < 4096; i++) mdl[i] = 8'h00;
    rst_n = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_addr = 16'h0;
    bus.ld_data = 32'h0;
    bus.ld_be = 4'h0;
    bus.ld_done = 1'b0;
    bus.fetch_req = 1'b0;
    bus.fetch_addr = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst_n = 1'b1;

    // IDLE ignores fetches, then the loader fills words and moves to LOAD.
    tick(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b1, 16'h0);
    tick(1'b1, 16'h0000, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 16'h0);
    tick(1'b1, 16'h0004, 32'h11223344, 4'hF, 1'b0, 1'b0, 16'h0);
    tick(1'b1, 16'h0004, 32'h0000AA00, 4'h2, 1'b0, 1'b0, 16'h0);
    tick(1'b1, 16'h0FFC, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 16'h0);
    tick(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b1, 16'h0000);
    tick(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 1'b0, 16'h0);

    // RUN: back-to-back fetches, misaligned, out of range, both (align wins), hold.
    tick(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b1, 16'h0000);
    tick(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b1, 16'h0004);
    check_val("req021_word", bus.instr_out, 32'h1122AA44);
    tick(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b1, 16'h0FFC);
    tick(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b1, 16'h0002);
    tick(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b1, 16'h1000);
    tick(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b1, 16'h1002);
    idle();
    idle();

    // Load/fetch collision in RUN, then a fetch right after the write.
    tick(1'b1, 16'h0008, 32'h55667788, 4'hF, 1'b0, 1'b1, 16'h0000);
    tick(1'b1, 16'h0008, 32'h55667788, 4'hF, 1'b0, 1'b0, 16'h0);
    tick(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b1, 16'h0008);

    // Bad loads are dropped, and the targets keep their old contents.
    tick(1'b1, 16'h0001, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b0, 16'h0);
    tick(1'b1, 16'h1000, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b0, 16'h0);
    tick(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b1, 16'h0000);
    tick(1'b1, 16'h0004, 32'hA5A5A5A5, 4'b1001, 1'b0, 1'b0, 16'h0);
    tick(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b1, 16'h0004);

    // Reset lands while a granted fetch is in flight.
    bus.fetch_req = 1'b1;
    bus.fetch_addr = 16'h0000;
    #1;
    check_val("pre_rst_gnt", {31'd0, bus.fetch_gnt}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.fetch_req = 1'b0;
    #1;
    check_reset_vals("midrst");
    sb_q.delete();
    exp_state = S_IDLE;
    exp_cnt = 8'd0;
    exp_out = 32'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    idle();

    // Saturate the error counter with misaligned loads in LOAD.
    tick(1'b1, 16'h0010, 32'h0BADC0DE, 4'hF, 1'b0, 1'b0, 16'h0);
    tick(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 300; i++) begin
      tick(1'b1, 16'h0003, 32'h12345678, 4'hF, 1'b0, 1'b0, 16'h0);
    end
    check_val("cnt_sat", {24'd0, bus.err_cnt}, 32'd255);
    tick(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 1'b0, 16'h0);
    tick(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b1, 16'h0010);
    tick(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b1, 16'h0000);
    tick(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b1, 16'h1004);
    idle();
    check_val("sb_drained", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
